framebuffer: RTL and testbench
==============================

# framebuffer

Double-buffered pixel store between the GPU's pixel write port and the display scan-out. GPU pixel writes (`fb_x`, `fb_y`, `fb_color`, `fb_write`) always land in the back buffer. The display reads the front buffer with 1-cycle latency. A swap request is held pending and applied only during vertical blanking, so the display never shows a partially drawn frame.

## Interface
- `FB_WIDTH`, 400, pixels per line
- `FB_HEIGHT`, 240, lines per frame
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `fb_x`  in  $clog2(FB_WIDTH)+1  GPU write x
- `fb_y`  in  $clog2(FB_HEIGHT)+1  GPU write y
- `fb_color`  in  16  GPU write colour
- `fb_write`  in  1  write strobe
- `disp_x`  in  $clog2(FB_WIDTH)+1  scan-out read x
- `disp_y`  in  $clog2(FB_HEIGHT)+1  scan-out read y
- `disp_read`  in  1  read strobe
- `disp_color`  out  16  read data
- `disp_valid`  out  1  `disp_color` valid
- `vblank`  in  1  level, high during vertical blanking
- `swap_req`  in  1  swap request; its rising edge is the command
- `swap_pending`  out  1  swap requested, not yet applied
- `front_sel`  out  1  bank currently displayed (0 or 1)
- `frame_count`  out  8  completed swaps, wraps at 256

## Operation
- Two banks, each of FB_WIDTH*FB_HEIGHT words of 16 bits. Bank address = y*FB_WIDTH + x.
- Write path
  - When `fb_write`=1, `fb_x`<FB_WIDTH and `fb_y`<FB_HEIGHT, `fb_color` is written to bank `!front_sel` at the clock edge.
  - Out-of-range writes are dropped silently.
  - Colour is stored unmodified. Transparency is resolved upstream.
- Read path
  - When `disp_read`=1, bank `front_sel` is read.
  - An out-of-range read returns 0x0000, still with `disp_valid`=1.
- Swap FSM, states IDLE and PENDING
  - IDLE → PENDING on a `swap_req` rising edge. The edge detector's previous-value register resets to 0, so `swap_req` held high through reset counts as an edge on the first cycle after reset.
  - PENDING → IDLE on the first edge where `vblank`=1. On that edge `front_sel` toggles and `frame_count` increments.
  - A `swap_req` edge seen while in PENDING is ignored; it is not queued.
  - `swap_pending` = (state == PENDING).
- Simultaneous events
  - A write on the swap edge uses the pre-swap `front_sel`, so it lands in the bank that becomes front.
  - A read on the swap edge uses the pre-swap `front_sel`.
- Reset (any time, including mid-swap): state IDLE, `front_sel`=0, `frame_count`=0, `disp_color`=0, `disp_valid`=0, `swap_pending`=0. A pending swap is discarded. Memory contents are not reset.

## Timing
- Write: a single edge. A read of the same address issued after that edge sees the new value.
- Read: `disp_read` at edge N gives `disp_color`/`disp_valid` registered at edge N+1.
  - `disp_valid` deasserts the cycle after `disp_read`=0. `disp_color` holds its last value.
  - Throughput is 1 pixel per cycle.
- Swap: `swap_req` edge sampled at edge N gives `swap_pending`=1 after N. The earliest toggle is edge N+1, if `vblank`=1 there.
- No ready/backpressure on either port: both accept one access every cycle.

## Structure
- Shared package holds `FB_WIDTH`/`FB_HEIGHT` defaults and the swap state encoding, so the GPU and display timing blocks use the same values.
- One sub-module, `fb_ram`: simple dual-port RAM with 1 write port, 1 registered read port and parameter depth. It is instantiated twice.
- Top level holds the bank-select muxes, bounds checks, address multiply, swap FSM and counters.

## Test plan
- Reset, then write (3,2)=0xF801 with `front_sel`=0. Read (3,2) → 0x0000 (stale front bank, memory preloaded 0). Swap in vblank, read again → 0xF801.
- `swap_req` rises with `vblank`=0 → `swap_pending`=1 and `front_sel` unchanged for 100 cycles. Raise `vblank` → next edge `front_sel`=1, `frame_count`=1, `swap_pending`=0.
- Second `swap_req` edge while pending → exactly one toggle; `frame_count` rises by 1.
- Write (399,239)=0x1235 and (400,0)=0xFFFF, then swap and read → 0x1235, and (400,0) read → 0x0000 with `disp_valid`=1. No bank address other than that of (399,239) changes.
- Write on the exact swap edge → data appears in the new front bank.
- Assert `reset` low during PENDING → outputs take reset values immediately, without waiting for a clock edge. After release, `vblank`=1 produces no toggle.

Source files
------------

// File: rtl/framebuffer_pkg.sv
// Shared framebuffer constants and the swap-control state encoding.
// Both GPU-side and display-side timing blocks import these, so they agree on
// the default frame geometry and the swap state values.
package framebuffer_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 400;
  localparam int unsigned FB_HEIGHT_DEF = 240;
  localparam int unsigned COLOR_W       = 16;

  // Swap control: IDLE waits for a request edge, PENDING waits for vblank.
  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports:
//   clk           clock
//   we/waddr/wdata  write port, committed at the clock edge
//   re/raddr        read request; rdata updates at the next edge, holds otherwise
//   rdata           registered read data (read-before-write on same address)
// Contents are not reset.
module fb_ram
  import framebuffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_WIDTH_DEF * FB_HEIGHT_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/framebuffer.sv
// Double-buffered pixel store between the GPU write port and display scan-out.
// GPU writes always land in the back bank; the display reads the front bank
// with one cycle of latency. A swap request is held pending and applied only
// while vblank is high, so a partially drawn frame is never shown.
// Ports:
//   clk, reset (async, active-low)
//   fb_x/fb_y/fb_color/fb_write      GPU pixel write (out-of-range dropped)
//   disp_x/disp_y/disp_read          display read request
//   disp_color/disp_valid            read result, one cycle after the request
//   vblank                           vertical blanking level
//   swap_req                         swap command (rising edge)
//   swap_pending/front_sel/frame_count  swap status
module framebuffer
  import framebuffer_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(FB_WIDTH):0]  fb_x,
  input  logic [$clog2(FB_HEIGHT):0] fb_y,
  input  logic [COLOR_W-1:0]         fb_color,
  input  logic                       fb_write,
  input  logic [$clog2(FB_WIDTH):0]  disp_x,
  input  logic [$clog2(FB_HEIGHT):0] disp_y,
  input  logic                       disp_read,
  output logic [COLOR_W-1:0]         disp_color,
  output logic                       disp_valid,
  input  logic                       vblank,
  input  logic                       swap_req,
  output logic                       swap_pending,
  output logic                       front_sel,
  output logic [7:0]                 frame_count
);

  localparam int unsigned XW    = $clog2(FB_WIDTH) + 1;
  localparam int unsigned YW    = $clog2(FB_HEIGHT) + 1;
  localparam int unsigned DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);

  swap_state_e        state_q, state_d;
  logic               swap_req_q;
  logic               swap_edge_c;
  logic               do_swap_c;
  logic               front_sel_q;
  logic [7:0]         frame_count_q;
  logic               disp_valid_q;
  logic               rd_bank_q;
  logic               rd_hit_q;

  logic               wr_ok_c, rd_ok_c;
  logic [AW-1:0]      wr_addr_c, rd_addr_c;
  logic [COLOR_W-1:0] rdata0, rdata1;

  // Bounds checks and linear address (y*FB_WIDTH + x)
  assign wr_ok_c   = fb_write  && (fb_x   < XW'(FB_WIDTH)) && (fb_y   < YW'(FB_HEIGHT));
  assign rd_ok_c   = disp_read && (disp_x < XW'(FB_WIDTH)) && (disp_y < YW'(FB_HEIGHT));
  assign wr_addr_c = AW'(fb_y)   * AW'(FB_WIDTH) + AW'(fb_x);
  assign rd_addr_c = AW'(disp_y) * AW'(FB_WIDTH) + AW'(disp_x);

  // Bank 0 is back when front_sel=1; both ports use the pre-swap front_sel
  fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok_c && front_sel_q),
    .waddr (wr_addr_c),
    .wdata (fb_color),
    .re    (rd_ok_c && !front_sel_q),
    .raddr (rd_addr_c),
    .rdata (rdata0)
  );

  fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (wr_ok_c && !front_sel_q),
    .waddr (wr_addr_c),
    .wdata (fb_color),
    .re    (rd_ok_c && front_sel_q),
    .raddr (rd_addr_c),
    .rdata (rdata1)
  );

  assign swap_edge_c = swap_req && !swap_req_q;

  // Swap FSM next state; an edge seen while PENDING is dropped, not queued
  always_comb begin
    state_d   = state_q;
    do_swap_c = 1'b0;
    unique case (state_q)
      SWAP_IDLE: begin
        if (swap_edge_c) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (vblank) begin
          state_d   = SWAP_IDLE;
          do_swap_c = 1'b1;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // Swap state, bank select, frame counter and read-side bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SWAP_IDLE;
      swap_req_q    <= 1'b0;
      front_sel_q   <= 1'b0;
      frame_count_q <= 8'd0;
      disp_valid_q  <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_hit_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      swap_req_q   <= swap_req;
      disp_valid_q <= disp_read;
      if (do_swap_c) begin
        front_sel_q   <= !front_sel_q;
        frame_count_q <= frame_count_q + 8'd1;
      end
      // Hold the select on idle cycles so disp_color keeps its last value
      if (disp_read) begin
        rd_bank_q <= front_sel_q;
        rd_hit_q  <= rd_ok_c;
      end
    end
  end

  // Out-of-range reads (and the reset state) present zero
  assign disp_color   = rd_hit_q ? (rd_bank_q ? rdata1 : rdata0) : '0;
  assign disp_valid   = disp_valid_q;
  assign swap_pending = (state_q == SWAP_PENDING);
  assign front_sel    = front_sel_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_framebuffer.sv
// Directed plus randomized checks of framebuffer against a frame-level model.
module tb_framebuffer;
  import framebuffer_pkg::*;

  localparam int W  = 400;
  localparam int H  = 240;
  localparam int XW = $clog2(W) + 1;
  localparam int YW = $clog2(H) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [XW-1:0] fb_x, disp_x;
  logic [YW-1:0] fb_y, disp_y;
  logic [15:0]   fb_color;
  logic          fb_write, disp_read, vblank, swap_req;
  logic [15:0]   disp_color;
  logic          disp_valid, swap_pending, front_sel;
  logic [7:0]    frame_count;

  framebuffer dut (
    .clk(clk), .reset(reset),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .disp_x(disp_x), .disp_y(disp_y), .disp_read(disp_read),
    .disp_color(disp_color), .disp_valid(disp_valid),
    .vblank(vblank), .swap_req(swap_req),
    .swap_pending(swap_pending), .front_sel(front_sel), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: pixel store per bank plus displayed-bank bookkeeping
  logic [15:0] m_mem [int];
  bit          m_front, m_pending, m_prev, m_valid, m_color_known;
  int          m_count;
  logic [15:0] m_color;

  function automatic int key(input bit bank, input int x, input int y);
    return (bank ? 200000 : 0) + y * W + x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_pending = 0; m_prev = 0; m_valid = 0;
    m_count = 0; m_color = 16'h0000; m_color_known = 1;
  endtask

  task automatic check_outputs();
    chk("disp_valid", 32'(disp_valid), 32'(m_valid));
    if (m_color_known) chk("disp_color", 32'(disp_color), 32'(m_color));
    chk("swap_pending", 32'(swap_pending), 32'(m_pending));
    chk("front_sel", 32'(front_sel), 32'(m_front));
    chk("frame_count", 32'(frame_count), 32'(m_count));
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge
  task automatic tick();
    int  ka;
    bit  edge_seen;
    if (disp_read) begin
      m_valid = 1;
      if (int'(disp_x) < W && int'(disp_y) < H) begin
        ka = key(m_front, int'(disp_x), int'(disp_y));
        m_color_known = m_mem.exists(ka);
        if (m_color_known) m_color = m_mem[ka];
      end else begin
        m_color = 16'h0000;
        m_color_known = 1;
      end
    end else begin
      m_valid = 0;
    end
    if (fb_write && int'(fb_x) < W && int'(fb_y) < H)
      m_mem[key(!m_front, int'(fb_x), int'(fb_y))] = fb_color;
    edge_seen = swap_req && !m_prev;
    m_prev = swap_req;
    if (m_pending) begin
      if (vblank) begin
        m_front = !m_front;
        m_count = (m_count + 1) % 256;
        m_pending = 0;
      end
    end else if (edge_seen) begin
      m_pending = 1;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic wr(input int x, input int y, input logic [15:0] c);
    fb_x = XW'(x); fb_y = YW'(y); fb_color = c; fb_write = 1;
    tick();
    fb_write = 0;
  endtask

  task automatic rd(input int x, input int y);
    disp_x = XW'(x); disp_y = YW'(y); disp_read = 1;
    tick();
    disp_read = 0;
  endtask

  task automatic do_swap();
    swap_req = 1; tick();
    swap_req = 0; vblank = 1; tick();
    vblank = 0;
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic reset_pulse();
    #2 reset = 0;
    #1 model_reset();
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    reset = 1;
  endtask

  initial begin
    reset = 0; fb_x = '0; fb_y = '0; fb_color = '0; fb_write = 0;
    disp_x = '0; disp_y = '0; disp_read = 0; vblank = 0; swap_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    reset = 1;

    // Give (3,2) a known zero in both banks, returning to front_sel=0
    wr(3, 2, 16'h0000); do_swap();
    wr(3, 2, 16'h0000); do_swap();

    // Write lands in the back bank only
    wr(3, 2, 16'hF801);
    rd(3, 2);
    chk("stale_front", 32'(disp_color), 32'h0000);
    do_swap();
    rd(3, 2);
    chk("after_swap", 32'(disp_color), 32'hF801);
    repeat (3) tick();  // disp_valid drops, disp_color holds

    // Swap waits for vblank
    swap_req = 1; tick(); swap_req = 0;
    repeat (100) tick();
    vblank = 1; tick(); vblank = 0;
    tick();

    // Second request edge while pending is ignored
    swap_req = 1; tick(); swap_req = 0; tick();
    swap_req = 1; tick(); swap_req = 0; tick();
    vblank = 1; repeat (4) tick(); vblank = 0;

    // Boundary pixel, out-of-range writes, and aliasing neighbours untouched
    wr(398, 239, 16'h0AAA);
    wr(0, 1, 16'h0BBB);
    wr(0, 0, 16'h0CCC);
    wr(399, 239, 16'h1235);
    wr(400, 0, 16'hFFFF);
    wr(5, 240, 16'hEEEE);
    do_swap();
    rd(399, 239);
    chk("corner_pixel", 32'(disp_color), 32'h1235);
    rd(400, 0);
    chk("oob_read_color", 32'(disp_color), 32'h0000);
    chk("oob_read_valid", 32'(disp_valid), 32'h1);
    rd(0, 1);
    rd(398, 239);
    rd(0, 0);

    // Write on the exact swap edge goes to the bank that becomes front
    swap_req = 1; tick(); swap_req = 0;
    fb_x = XW'(10); fb_y = YW'(10); fb_color = 16'hABCD; fb_write = 1; vblank = 1;
    tick();
    fb_write = 0; vblank = 0;
    rd(10, 10);
    chk("swap_edge_write", 32'(disp_color), 32'hABCD);

    // Randomized traffic over a small window plus occasional out-of-range
    for (int i = 0; i < 600; i++) begin
      fb_write  = 1'($urandom_range(0, 1));
      fb_x      = ($urandom_range(0, 7) == 0) ? XW'($urandom_range(400, 1023)) : XW'($urandom_range(0, 7));
      fb_y      = YW'($urandom_range(0, 3));
      fb_color  = 16'($urandom);
      disp_read = 1'($urandom_range(0, 3) != 0);
      disp_x    = ($urandom_range(0, 7) == 0) ? XW'($urandom_range(400, 1023)) : XW'($urandom_range(0, 7));
      disp_y    = ($urandom_range(0, 9) == 0) ? YW'($urandom_range(240, 511)) : YW'($urandom_range(0, 3));
      swap_req  = 1'($urandom_range(0, 1));
      vblank    = ($urandom_range(0, 3) == 0);
      tick();
    end
    fb_write = 0; disp_read = 0; swap_req = 0; vblank = 0;
    tick();

    // Reset during PENDING discards the swap
    swap_req = 1; tick(); swap_req = 0;
    reset_pulse();
    vblank = 1; repeat (5) tick(); vblank = 0;
    chk("no_toggle_after_reset", 32'(front_sel), 32'h0);

    // swap_req held high through reset counts as an edge
    swap_req = 1;
    reset_pulse();
    tick();
    chk("held_req_pending", 32'(swap_pending), 32'h1);
    vblank = 1; tick(); vblank = 0; swap_req = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
